// File: rtl/lab5_addr_seq.sv
// rtl/lab5_addr_seq.sv - 3-bit LED-decoder address sequencer with auto and manual advance
//
// Purpose
//   Holds a 3-bit select code (A2..A0) for a 3-to-8 LED decoder.
//   The code advances in one of two ways:
//     - Auto mode (run=1): once every PRESCALE clocks.
//     - Manual mode (run=0): once per rising edge of the asynchronous step button.
//   The count goes up when dir=1 and down when dir=0, modulo 8.
//   The outputs tick and wrap are one-cycle pulses that mark a code change and a 7<->0 wrap.
//
// Parameters
//   PRESCALE      clocks per auto-advance (>= 1)
//   DEBOUNCE_CYC  stable cycles needed before the debounced step level may change (>= 1)
//
// Configuration
//   LAB5_DEBOUNCE_EN  when defined, a debouncer sits between the synchronizer and the
//                     edge detector. When undefined, no debounce logic is built.
//
// Ports
//   clk     in   system clock; all state changes on the rising edge
//   rst_n   in   asynchronous active-low reset
//   run     in   1 = auto-advance, 0 = manual step
//   dir     in   1 = count up, 0 = count down
//   step    in   asynchronous push-button
//   clr     in   synchronous clear of the code; takes priority over any advance
//   A0..A2  out  registered select code, A0 = LSB
//   tick    out  one-cycle pulse: the code changed on the preceding edge
//   wrap    out  one-cycle pulse: that change wrapped 7->0 (up) or 0->7 (down)

module lab5_addr_seq #(
    parameter int PRESCALE     = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic dir,
    input  logic step,
    input  logic clr,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic tick,
    output logic wrap
);

    // Parameter legality is checked at elaboration, so an illegal build never produces a netlist.
    if (PRESCALE < 1 || DEBOUNCE_CYC < 1) begin : g_bad_params
        $error("lab5_addr_seq: PRESCALE and DEBOUNCE_CYC must both be >= 1");
    end

    // The prescaler needs at least one bit, even when PRESCALE=1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [2:0]    code;
    logic [PW-1:0] presc;

    // ------------------------------------------------------------------
    // Step button path: 2-flop synchronizer -> (optional debounce) -> edge detect
    // ------------------------------------------------------------------
    logic step_s1;
    logic step_s2;
    logic step_lvl;
    logic step_prev;
    logic step_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
        end else begin
            step_s1 <= step;
            step_s2 <= step_s1;
        end
    end

`ifdef LAB5_DEBOUNCE_EN
    localparam int DCW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DCW-1:0] DB_MAX = DCW'(DEBOUNCE_CYC - 1);

    logic           db_lvl;
    logic [DCW-1:0] db_cnt;

    // db_cnt counts consecutive cycles in which the synchronized input disagrees
    // with the debounced level. The level follows the input only after DEBOUNCE_CYC
    // such cycles in a row. Any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl <= 1'b0;
            db_cnt <= '0;
        end else if (step_s2 == db_lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            db_lvl <= step_s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DCW'(1);
        end
    end

    assign step_lvl = db_lvl;
`else
    assign step_lvl = step_s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_lvl;
        end
    end

    assign step_rise = step_lvl & ~step_prev;

    // ------------------------------------------------------------------
    // Advance decision
    // ------------------------------------------------------------------
    logic       auto_adv;
    logic       man_adv;
    logic       advance;
    logic [2:0] code_next;
    logic       wrap_next;

    // Auto mode needs both the RUN state and a live run input. On the edge where run
    // drops, the FSM is still in RUN, so the run term stops a stray advance on that edge.
    // Step edges seen while in RUN are not queued; they are simply dropped.
    assign auto_adv  = (state == RUN) && run && (presc == PRE_MAX);
    assign man_adv   = (state == IDLE) && step_rise;
    assign advance   = auto_adv || man_adv;

    // dir is sampled on the advancing edge itself.
    assign code_next = dir ? (code + 3'd1) : (code - 3'd1);
    assign wrap_next = dir ? (code == 3'd7) : (code == 3'd0);

    // ------------------------------------------------------------------
    // FSM, prescaler, code and output pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
            code  <= 3'd0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;

            // presc holds 0 in IDLE and on the IDLE->RUN edge. The first auto-advance
            // therefore lands PRESCALE edges after the FSM enters RUN.
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= IDLE;
                        presc <= '0;
                    end else if (presc == PRE_MAX) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    presc <= '0;
                end
            endcase

            // clr overrides any advance: no tick, no wrap, and the prescale phase restarts.
            // The state transition above is left alone, so the FSM still follows run.
            if (clr) begin
                code  <= 3'd0;
                presc <= '0;
            end else if (advance) begin
                code <= code_next;
                tick <= 1'b1;
                wrap <= wrap_next;
            end
        end
    end

    assign A0 = code[0];
    assign A1 = code[1];
    assign A2 = code[2];

endmodule

// File: tb/tb_lab5_addr_seq.sv
// tb/tb_lab5_addr_seq.sv - self-checking bench for lab5_addr_seq (default build, PRESCALE=4)

module tb_lab5_addr_seq;

    localparam int PRESCALE = 4;

    logic clk;
    logic rst_n;
    logic run;
    logic dir;
    logic step;
    logic clr;
    logic A0;
    logic A1;
    logic A2;
    logic tick;
    logic wrap;

    int n_tests = 0;
    int n_fail  = 0;

    lab5_addr_seq #(
        .PRESCALE    (PRESCALE),
        .DEBOUNCE_CYC(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .dir  (dir),
        .step (step),
        .clr  (clr),
        .A0   (A0),
        .A1   (A1),
        .A2   (A2),
        .tick (tick),
        .wrap (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model, built from the behavioural rules:
    //   - A step press advances the code on edge n when step was sampled 0 on edge n-3
    //     and 1 on edge n-2 (synchronizer plus edge detect), but only if run was 0 on
    //     edge n-1, i.e. the sequencer was idle.
    //   - Auto mode advances on every PRESCALE-th run=1 edge after entering RUN. The
    //     count restarts after each advance and after each clr.
    //   - clr wins over everything.
    // ------------------------------------------------------------------
    logic       h1, h2, h3;      // step sampled on the last three edges (h1 = most recent)
    logic       m_inrun;         // run sampled on the previous edge
    int         m_since;         // run edges since entry, last advance or clr
    logic [2:0] m_code;
    logic       m_tick;
    logic       m_wrap;

    logic       m_auto;
    logic       m_man;
    logic       m_adv;
    logic [2:0] m_ncode;
    logic       m_nwrap;

    always_comb begin
        m_auto  = m_inrun && run && (m_since + 1 == PRESCALE);
        m_man   = !m_inrun && h2 && !h3;
        m_adv   = (m_auto || m_man) && !clr;
        m_ncode = dir ? 3'((m_code + 1) % 8) : 3'((m_code + 7) % 8);
        m_nwrap = m_adv && (dir ? (m_code == 3'd7) : (m_code == 3'd0));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1      <= 1'b0;
            h2      <= 1'b0;
            h3      <= 1'b0;
            m_inrun <= 1'b0;
            m_since <= 0;
            m_code  <= 3'd0;
            m_tick  <= 1'b0;
            m_wrap  <= 1'b0;
        end else begin
            h1      <= step;
            h2      <= h1;
            h3      <= h2;
            m_inrun <= run;
            m_since <= (m_inrun && run && !clr && !m_auto) ? m_since + 1 : 0;
            m_code  <= clr ? 3'd0 : (m_adv ? m_ncode : m_code);
            m_tick  <= m_adv;
            m_wrap  <= m_nwrap;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_code", int'({A2, A1, A0}), int'(m_code));
            chk("model_tick", int'(tick), int'(m_tick));
            chk("model_wrap", int'(wrap), int'(m_wrap));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int c, input int t, input int w);
        chk({name, "_code"}, int'({A2, A1, A0}), c);
        chk({name, "_tick"}, int'(tick), t);
        chk({name, "_wrap"}, int'(wrap), w);
    endtask

    task automatic do_reset;
        run   = 1'b0;
        clr   = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        #1;
        lit("reset", 0, 0, 0);
        #1;
        rst_n = 1'b1;
        edges(1);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        dir   = 1'b1;
        step  = 1'b0;
        clr   = 1'b0;
        #1;
        lit("por", 0, 0, 0);
        #2;
        rst_n = 1'b1;
        edges(1);

        // Auto up-count: 1 after 4 edges in RUN, ..., back to 0 with wrap after 32.
        run = 1'b1;
        dir = 1'b1;
        edges(1);                       // IDLE -> RUN
        for (int k = 1; k <= 8; k++) begin
            edges(4);
            lit("up", k % 8, 1, (k == 8) ? 1 : 0);
        end

        // Reset mid-run takes effect at once; the partial prescale count is dropped.
        edges(6);
        #2;
        rst_n = 1'b0;
        #1;
        lit("async_rst", 0, 0, 0);
        #3;
        rst_n = 1'b1;
        edges(1);                       // IDLE -> RUN with run still high
        edges(3);
        lit("post_rst_hold", 0, 0, 0);
        edges(1);
        lit("post_rst_adv", 1, 1, 0);
        run = 1'b0;
        edges(2);

        // Down wrap: 0 -> 7 with wrap, then 6 without.
        do_reset();
        run = 1'b1;
        dir = 1'b0;
        edges(1);
        edges(4);
        lit("down_wrap", 7, 1, 1);
        edges(4);
        lit("down_next", 6, 1, 0);
        run = 1'b0;
        edges(2);

        // Manual step: a 5-cycle press gives exactly one advance, 3 edges after the rise.
        do_reset();
        dir  = 1'b1;
        step = 1'b1;
        edges(2);
        lit("step_lat2", 0, 0, 0);
        edges(1);
        lit("step_lat3", 1, 1, 0);
        edges(2);
        step = 1'b0;
        edges(5);
        lit("step_once", 1, 0, 0);
        dir  = 1'b0;
        step = 1'b1;
        edges(1);
        step = 1'b0;
        edges(6);
        lit("step_dn", 0, 0, 0);
        step = 1'b1;
        edges(1);
        step = 1'b0;
        edges(2);
        lit("step_dn_wrap", 7, 1, 1);
        edges(3);

        // clr on the terminal-count edge with code=5; the next advance comes 4 edges later.
        do_reset();
        run = 1'b1;
        dir = 1'b1;
        edges(1);
        edges(20);
        lit("pre_clr", 5, 1, 0);
        edges(3);
        clr = 1'b1;
        edges(1);
        lit("clr_hit", 0, 0, 0);
        clr = 1'b0;
        edges(3);
        lit("clr_gap", 0, 0, 0);
        edges(1);
        lit("clr_next", 1, 1, 0);
        clr = 1'b1;
        edges(10);
        lit("clr_held", 0, 0, 0);
        clr = 1'b0;
        run = 1'b0;
        edges(2);

        // Step toggling during RUN must not change the auto sequence.
        do_reset();
        run = 1'b1;
        dir = 1'b1;
        edges(1);
        for (int e = 1; e <= 32; e++) begin
            if (e % 3 == 0) step = ~step;
            edges(1);
            if (e % 4 == 0) lit("run_step", (e / 4) % 8, 1, (e == 32) ? 1 : 0);
        end
        step = 1'b0;
        edges(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lab5_addr_seq.md
LAB5_ADDR_SEQ -- requirements
Module: lab5_addr_seq

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, clock cycles per auto-advance (legal range >=1).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 8, stable-high cycles required for a debounced step (used only with LAB5_DEBOUNCE_EN).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  input  1  1 = auto-advance mode, 0 = manual step mode.
REQ-006 SHALL have port dir  input  1  1 = count up, 0 = count down.
REQ-007 SHALL have port step  input  1  asynchronous push-button, each press advances code once in manual mode.
REQ-008 SHALL have port clr  input  1  synchronous clear of code to 0.
REQ-009 SHALL have ports A0, A1, A2  output  1 each  3-bit select code, A0 LSB, driving the 3-to-8 LED decoder directly.
REQ-010 SHALL have port tick  output  1  one-cycle pulse, code changed on this edge.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse, code wrapped 7->0 (up) or 0->7 (down).

Function
REQ-012 SHALL hold code in a 3-bit register, modulo-8 arithmetic; all outputs registered.
REQ-013 SHALL implement FSM states IDLE and RUN; IDLE->RUN when run=1, RUN->IDLE when run=0, evaluated every edge.
REQ-014 SHALL in RUN keep prescaler 0..PRESCALE-1; on edge where state=RUN, run=1, prescaler=PRESCALE-1: advance code, prescaler->0.
REQ-015 SHALL clear prescaler to 0 on IDLE->RUN and in IDLE, so first advance occurs PRESCALE cycles after entering RUN; PRESCALE=1 advances every RUN cycle.
REQ-016 SHALL pass step through a 2-flop synchronizer, then rising-edge detect; one advance per detected edge, only in IDLE.
REQ-017 SHALL ignore step edges while in RUN (not queued).
REQ-018 SHALL apply dir at the advancing edge; dir change mid-count affects only the next advance.
REQ-019 SHALL assert tick and, when applicable, wrap in the cycle following the advancing edge, for exactly one cycle.
REQ-020 SHALL give clr priority over any advance: code->0, prescaler->0, tick=0, wrap=0 that edge; state still follows run.
REQ-021 SHALL with clr held keep code at 0 and produce no tick.
REQ-022 SHALL produce step-to-code latency of 3 edges (2 sync + 1 edge detect/update) without debounce.

Reset
REQ-023 SHALL on rst_n=0, without waiting for clk: A2..A0=000, tick=0, wrap=0, state=IDLE, prescaler=0, synchronizer/edge/debounce registers=0.
REQ-024 SHALL after rst_n release resume normal operation from the first rising clk edge; reset mid-run abandons the partial prescale count.

Configuration
REQ-025 SHALL with macro LAB5_DEBOUNCE_EN defined insert a debouncer after the synchronizer: debounced level goes 1 only after DEBOUNCE_CYC consecutive synchronized-high cycles and 0 after DEBOUNCE_CYC consecutive lows; edge detect acts on debounced level; latency = 3 + DEBOUNCE_CYC edges.
REQ-026 SHALL with LAB5_DEBOUNCE_EN undefined omit the debouncer entirely (no counter logic); edge detect acts on synchronized step, so each glitch-free high pulse of >=1 cycle yields one advance.

Verification (PRESCALE=4)
REQ-027 SHALL cover reset: rst_n=0 mid-run, no clk edge -> A2..A0=000, tick=0, wrap=0 immediately.
REQ-028 SHALL cover auto up-count: run=1, dir=1 from 0 -> code 1 after 4 edges, 2 after 8, ..., 7 after 28, 0 after 32 with tick=1 and wrap=1 that cycle.
REQ-029 SHALL cover down wrap: run=1, dir=0 from 0 -> code 7 after 4 edges with wrap=1; next 6 after 8 with wrap=0.
REQ-030 SHALL cover manual step: run=0, step high 5 cycles (debounce off) -> code 0->1 exactly once, tick pulse 3 edges after step rise; with LAB5_DEBOUNCE_EN and DEBOUNCE_CYC=8, 5-cycle press -> no change, 12-cycle press -> one increment.
REQ-031 SHALL cover clr collision: clr=1 on the terminal-count edge with code=5 -> code=0, tick=0, wrap=0; next advance 4 edges after clr drops.
REQ-032 SHALL cover step during RUN: step edges while run=1 -> no extra advances, code sequence identical to REQ-028.
